// File: rtl/btb_pkg.sv
// Shared types, counter encodings and index/tag helpers for the BTB.
package btb_pkg;

    localparam int TAG_MAX = 29;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // tag is sized for the smallest table; unused upper bits stay zero
    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        logic [31:0]        target;
        logic [1:0]         ctr;
    } btb_entry_t;

    function automatic logic [31:0] btb_idx(input logic [31:0] pc,
                                            input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [TAG_MAX-1:0] btb_tag(input logic [31:0] pc,
                                                   input int idx_w);
        logic [31:0] t;
        t = pc >> (idx_w + 2);
        return t[TAG_MAX-1:0];
    endfunction

endpackage

// File: rtl/btb_predictor_sat_ctr.sv
// 2-bit saturating direction counter next-state logic.
module btb_sat_ctr
    import btb_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        unique case (1'b1)
            taken_i && ctr_i != CTR_ST:   ctr_o = ctr_i + 2'd1;
            !taken_i && ctr_i != CTR_SNT: ctr_o = ctr_i - 2'd1;
            default:                      ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and mispredict detect.
// Optional counters enabled by defining BTB_STATS_EN.
module btb_predictor
    import btb_pkg::*;
#(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int TAG_W   = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_if,
    output logic        hit,
    output logic [31:0] brb,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_hit,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] pc_redirect,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    btb_entry_t       tbl_q [ENTRIES];
    btb_entry_t       rd_e;
    btb_entry_t       wr_e;
    btb_entry_t       entry_d;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] up_tag;
    logic [1:0]       ctr_nxt;
    logic             up_match;
    logic             we;

    assign if_idx = IDX_W'(btb_idx(pc_if, IDX_W));
    assign if_tag = TAG_W'(btb_tag(pc_if, IDX_W));
    assign up_idx = IDX_W'(btb_idx(upd_pc, IDX_W));
    assign up_tag = TAG_W'(btb_tag(upd_pc, IDX_W));

    // lookup reads registered state only, so a same-cycle write is not seen
    assign rd_e = tbl_q[if_idx];
    assign hit  = rd_e.valid && rd_e.tag == TAG_MAX'(if_tag) && rd_e.ctr[1];
    assign brb  = hit ? rd_e.target : 32'd0;

    assign wr_e     = tbl_q[up_idx];
    assign up_match = wr_e.valid && wr_e.tag == TAG_MAX'(up_tag);

    btb_sat_ctr u_ctr (
        .ctr_i   (wr_e.ctr),
        .taken_i (upd_taken),
        .ctr_o   (ctr_nxt)
    );

    always_comb begin
        entry_d = wr_e;
        we      = 1'b0;
        if (upd_valid) begin
            if (up_match) begin
                we          = 1'b1;
                entry_d.ctr = ctr_nxt;
                if (upd_taken) entry_d.target = upd_target;
            end else if (upd_taken) begin
                we             = 1'b1;
                entry_d.valid  = 1'b1;
                entry_d.tag    = TAG_MAX'(up_tag);
                entry_d.target = upd_target;
                entry_d.ctr    = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i].valid  <= 1'b0;
                tbl_q[i].tag    <= '0;
                tbl_q[i].target <= '0;
                tbl_q[i].ctr    <= CTR_WNT;
            end
        end else if (we) begin
            tbl_q[up_idx] <= entry_d;
        end
    end

    assign mispredict = upd_valid &&
        ((upd_pred_hit != upd_taken) ||
         (upd_taken && upd_pred_hit && upd_pred_target != upd_target));

    assign pc_redirect = !mispredict ? 32'd0 :
                         upd_taken   ? upd_target : upd_pc + 32'd4;

`ifdef BTB_STATS_EN
    logic [31:0] br_q;
    logic [31:0] mp_q;
    logic [31:0] br_d;
    logic [31:0] mp_d;

    always_comb begin
        br_d = br_q;
        mp_d = mp_q;
        if (upd_valid && br_q != '1) br_d = br_q + 32'd1;
        if (mispredict && mp_q != '1) mp_d = mp_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_q <= '0;
            mp_q <= '0;
        end else begin
            br_q <= br_d;
            mp_q <= mp_d;
        end
    end

    assign stat_branches    = br_q;
    assign stat_mispredicts = mp_q;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed table plus randomized model check for btb_predictor.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_if;
    logic        hit;
    logic [31:0] brb;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_hit;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] pc_redirect;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int nvec = 0;
    int nerr = 0;
    int exp_br = 0;
    int exp_mp = 0;

    always #5 clk = ~clk;

    btb_predictor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_if            (pc_if),
        .hit              (hit),
        .brb              (brb),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_hit     (upd_pred_hit),
        .upd_pred_target  (upd_pred_target),
        .mispredict       (mispredict),
        .pc_redirect      (pc_redirect),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    typedef struct {
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        tk;
        logic [31:0] tgt;
        logic        ph;
        logic [31:0] pt;
        logic        e_hit;
        logic [31:0] e_brb;
        logic        e_mis;
        logic [31:0] e_red;
    } vec_t;

    vec_t tbl [$];

    // behavioural model: slot = word address mod 16, tag = pc / 64
    bit          m_v   [16];
    int unsigned m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_ctr [16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_stats();
`ifdef BTB_STATS_EN
        chk("stat_branches", stat_branches, exp_br);
        chk("stat_mispredicts", stat_mispredicts, exp_mp);
`else
        chk("stat_branches", stat_branches, 32'd0);
        chk("stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    endtask

    function automatic vec_t mk(logic [31:0] pc, logic uv, logic [31:0] upc,
                                logic tk, logic [31:0] tgt, logic ph,
                                logic [31:0] pt, logic eh, logic [31:0] eb,
                                logic em, logic [31:0] er);
        vec_t v;
        v.pc = pc; v.uv = uv; v.upc = upc; v.tk = tk; v.tgt = tgt;
        v.ph = ph; v.pt = pt; v.e_hit = eh; v.e_brb = eb;
        v.e_mis = em; v.e_red = er;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        pc_if           = v.pc;
        upd_valid       = v.uv;
        upd_pc          = v.upc;
        upd_taken       = v.tk;
        upd_target      = v.tgt;
        upd_pred_hit    = v.ph;
        upd_pred_target = v.pt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        exp_br = 0;
        exp_mp = 0;
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
    endtask

    function automatic logic m_hit(input logic [31:0] pc);
        int s;
        s = int'((pc >> 2) % 16);
        return m_v[s] && m_tag[s] == (pc >> 6) && m_ctr[s] >= 2;
    endfunction

    function automatic logic [31:0] m_brb(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[int'((pc >> 2) % 16)] : 32'd0;
    endfunction

    task automatic m_update(input logic [31:0] pc, input logic tk,
                            input logic [31:0] tgt);
        int s;
        s = int'((pc >> 2) % 16);
        if (m_v[s] && m_tag[s] == (pc >> 6)) begin
            m_ctr[s] = tk ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3)
                          : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
            if (tk) m_tgt[s] = tgt;
        end else if (tk) begin
            m_v[s] = 1; m_tag[s] = pc >> 6; m_tgt[s] = tgt; m_ctr[s] = 2;
        end
    endtask

    function automatic logic [31:0] rpc();
        return ({31'd0, 1'($urandom_range(0, 1))} << 31) |
               (32'($urandom_range(0, 3)) << 6) |
               (32'($urandom_range(0, 15)) << 2) |
               32'($urandom_range(0, 3));
    endfunction

    initial begin
        vec_t v;
        logic e_mis;
        logic [31:0] e_red;

        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        do_reset();

        tbl.push_back(mk('h100, 0, 0,     0, 0,     0, 0,     0, 0,     0, 0));
        tbl.push_back(mk('h100, 1, 'h100, 1, 'h200, 0, 0,     0, 0,     1, 'h200));
        tbl.push_back(mk('h100, 0, 0,     0, 0,     0, 0,     1, 'h200, 0, 0));
        tbl.push_back(mk('h100, 1, 'h100, 0, 0,     1, 'h200, 1, 'h200, 1, 'h104));
        tbl.push_back(mk('h100, 1, 'h100, 0, 0,     0, 0,     0, 0,     0, 0));
        tbl.push_back(mk('h100, 0, 0,     0, 0,     0, 0,     0, 0,     0, 0));
        tbl.push_back(mk('h100, 1, 'h100, 1, 'h200, 0, 0,     0, 0,     1, 'h200));
        tbl.push_back(mk('h100, 1, 'h100, 1, 'h200, 0, 0,     0, 0,     1, 'h200));
        tbl.push_back(mk('h100, 0, 0,     0, 0,     0, 0,     1, 'h200, 0, 0));
        tbl.push_back(mk('h100, 1, 'h140, 1, 'h300, 0, 0,     1, 'h200, 1, 'h300));
        tbl.push_back(mk('h100, 0, 0,     0, 0,     0, 0,     0, 0,     0, 0));
        tbl.push_back(mk('h140, 0, 0,     0, 0,     0, 0,     1, 'h300, 0, 0));
        tbl.push_back(mk('h140, 1, 'h100, 1, 'h200, 0, 0,     1, 'h300, 1, 'h200));
        tbl.push_back(mk('h100, 1, 'h100, 1, 'h200, 1, 'h200, 1, 'h200, 0, 0));
        tbl.push_back(mk('h100, 1, 'h100, 1, 'h280, 1, 'h200, 1, 'h200, 1, 'h280));
        tbl.push_back(mk('h100, 0, 0,     0, 0,     0, 0,     1, 'h280, 0, 0));
        tbl.push_back(mk('h104, 0, 'h104, 1, 'h500, 0, 0,     0, 0,     0, 0));
        tbl.push_back(mk('h102, 0, 0,     0, 0,     0, 0,     1, 'h280, 0, 0));
        tbl.push_back(mk('hFFFFFFFC, 1, 'hFFFFFFFC, 0, 0, 1, 'h40, 0, 0, 1, 'h0));

        @(negedge clk);
        chk_stats();

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1 drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("v%0d hit", i), hit, tbl[i].e_hit);
            chk($sformatf("v%0d brb", i), brb, tbl[i].e_brb);
            chk($sformatf("v%0d mispredict", i), mispredict, tbl[i].e_mis);
            chk($sformatf("v%0d pc_redirect", i), pc_redirect, tbl[i].e_red);
            if (tbl[i].uv) exp_br++;
            if (tbl[i].e_mis) exp_mp++;
        end
        @(posedge clk);
        #1 drive(mk('h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk_stats();
        chk("pre-reset hit", hit, 1'b1);

        // asynchronous reset drops the entry without a clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("async hit", hit, 1'b0);
        chk("async brb", brb, 32'd0);
        exp_br = 0;
        exp_mp = 0;
        chk_stats();
        drive(mk('h100, 1, 'h100, 1, 'h200, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 drive(mk('h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("write in reset", hit, 1'b0);

        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            v.pc  = rpc();
            v.uv  = ($urandom_range(0, 9) < 7);
            v.upc = rpc();
            v.tk  = 1'($urandom_range(0, 1));
            v.tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) begin
                v.ph = m_hit(v.upc);
                v.pt = ($urandom_range(0, 3) == 0) ? v.tgt : m_brb(v.upc);
            end else begin
                v.ph = 1'($urandom_range(0, 1));
                v.pt = ($urandom_range(0, 1) == 1) ? v.tgt : $urandom;
            end
            drive(v);
            e_mis = v.uv && ((v.ph != v.tk) ||
                             (v.tk && v.ph && v.pt != v.tgt));
            e_red = !e_mis ? 32'd0 : (v.tk ? v.tgt : v.upc + 32'd4);
            @(negedge clk);
            chk($sformatf("r%0d hit", n), hit, m_hit(v.pc));
            chk($sformatf("r%0d brb", n), brb, m_brb(v.pc));
            chk($sformatf("r%0d mispredict", n), mispredict, e_mis);
            chk($sformatf("r%0d pc_redirect", n), pc_redirect, e_red);
            chk_stats();
            if (v.uv) begin
                exp_br++;
                if (e_mis) exp_mp++;
                m_update(v.upc, v.tk, v.tgt);
            end
        end
        @(posedge clk);
        #1 drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk_stats();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
